// File: rtl/rv32imf_obi_master_buffered.sv
// OBI 1.x master adapter: holds the A channel stable until granted, limits
// outstanding transactions with a credit counter and buffers responses in a FIFO.
module rv32imf_obi_master_buffered #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int ATOP_W          = 6,
  parameter int MAX_OUTSTANDING = 2,
  parameter bit TRANS_STABLE    = 1'b0,
  parameter bit RESP_BYPASS     = 1'b1,
  localparam int BE_W           = DATA_W / 8,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trans_valid_i,
  output logic              trans_ready_o,
  input  logic [ADDR_W-1:0] trans_addr_i,
  input  logic              trans_we_i,
  input  logic [BE_W-1:0]   trans_be_i,
  input  logic [DATA_W-1:0] trans_wdata_i,
  input  logic [ATOP_W-1:0] trans_atop_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [CNT_W-1:0]  outstanding_o,
  output logic              obi_req_o,
  input  logic              obi_gnt_i,
  output logic [ADDR_W-1:0] obi_addr_o,
  output logic              obi_we_o,
  output logic [BE_W-1:0]   obi_be_o,
  output logic [DATA_W-1:0] obi_wdata_o,
  output logic [ATOP_W-1:0] obi_atop_o,
  input  logic [DATA_W-1:0] obi_rdata_i,
  input  logic              obi_rvalid_i,
  input  logic              obi_err_i
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {TRANSPARENT, REGISTERED} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ATOP_W-1:0]   atop_q, atop_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    occ_q, occ_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_W-1:0]   rdata_mem_q [MAX_OUTSTANDING];
  logic                err_mem_q   [MAX_OUTSTANDING];

  logic cnt_ok, fifo_empty, fifo_full, rvalid_ok, bypass;
  logic push, pop, accept, consume;
  logic a_req, a_ready;

  assign cnt_ok     = (cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == CNT_W'(MAX_OUTSTANDING));
  // A response with no credit outstanding is dropped rather than delivered.
  assign rvalid_ok  = obi_rvalid_i && (cnt_q != '0);
  assign bypass     = RESP_BYPASS && fifo_empty && resp_ready_i;
  assign push       = rvalid_ok && !bypass && !fifo_full;
  assign pop        = !fifo_empty && resp_ready_i;
  assign accept     = trans_valid_i && a_ready;
  assign consume    = resp_valid_o && resp_ready_i;
  assign outstanding_o = cnt_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    atop_d        = atop_q;
    a_req         = 1'b0;
    a_ready       = 1'b0;
    obi_addr_o    = trans_addr_i;
    obi_we_o      = trans_we_i;
    obi_be_o      = trans_be_i;
    obi_wdata_o   = trans_wdata_i;
    obi_atop_o    = trans_atop_i;
    if (TRANS_STABLE) begin
      a_req   = trans_valid_i && cnt_ok;
      a_ready = obi_gnt_i && cnt_ok;
    end else begin
      case (state_q)
        TRANSPARENT: begin
          a_req   = trans_valid_i && cnt_ok;
          a_ready = cnt_ok;
          if (a_req && !obi_gnt_i) begin
            state_d = REGISTERED;
            addr_d  = trans_addr_i;
            we_d    = trans_we_i;
            be_d    = trans_be_i;
            wdata_d = trans_wdata_i;
            atop_d  = trans_atop_i;
          end
        end
        REGISTERED: begin
          a_req       = 1'b1;
          obi_addr_o  = addr_q;
          obi_we_o    = we_q;
          obi_be_o    = be_q;
          obi_wdata_o = wdata_q;
          obi_atop_o  = atop_q;
          if (obi_gnt_i) state_d = TRANSPARENT;
        end
        default: state_d = TRANSPARENT;
      endcase
    end
    obi_req_o     = a_req;
    trans_ready_o = a_ready;
    // Combinational paths must stay quiet while reset is held.
    if (rst) begin
      obi_req_o     = 1'b0;
      trans_ready_o = 1'b0;
      obi_addr_o    = '0;
      obi_we_o      = 1'b0;
      obi_be_o      = '0;
      obi_wdata_o   = '0;
      obi_atop_o    = '0;
    end
  end

  always_comb begin
    resp_valid_o = !fifo_empty;
    resp_rdata_o = rdata_mem_q[rptr_q];
    resp_err_o   = err_mem_q[rptr_q];
    if (bypass) begin
      resp_valid_o = rvalid_ok;
      resp_rdata_o = obi_rdata_i;
      resp_err_o   = obi_err_i;
    end
    if (rst) begin
      resp_valid_o = 1'b0;
      resp_rdata_o = '0;
      resp_err_o   = 1'b0;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    occ_d  = occ_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (accept && !consume) cnt_d = cnt_q + CNT_W'(1);
    if (!accept && consume) cnt_d = cnt_q - CNT_W'(1);
    if (push && !pop) occ_d = occ_q + CNT_W'(1);
    if (!push && pop) occ_d = occ_q - CNT_W'(1);
    if (push) wptr_d = (wptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + PTR_W'(1);
    if (pop)  rptr_d = (rptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TRANSPARENT;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      atop_q  <= '0;
      cnt_q   <= '0;
      occ_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      atop_q  <= atop_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        rdata_mem_q[i] <= '0;
        err_mem_q[i]   <= 1'b0;
      end
    end else if (push) begin
      rdata_mem_q[wptr_q] <= obi_rdata_i;
      err_mem_q[wptr_q]   <= obi_err_i;
    end
  end

  rvalid_protocol: assert property (@(posedge clk) disable iff (rst)
    !(obi_rvalid_i && (fifo_full || cnt_q == '0)));

endmodule
